// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - MIPS-subset encodings, ALU control codes and decode-stage types
// Shared with the downstream ALU control so both sides agree on FuncCode/ALUOp values.
package isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] FC_ADD = 4'b0000;
   localparam logic [3:0] FC_SUB = 4'b0010;
   localparam logic [3:0] FC_AND = 4'b0100;
   localparam logic [3:0] FC_OR  = 4'b0101;
   localparam logic [3:0] FC_NOR = 4'b0111;
   localparam logic [3:0] FC_SLT = 4'b1010;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_FUNC = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK
   } state_e;

   typedef struct packed {
      logic [4:0]  read1;
      logic [4:0]  read2;
      logic [4:0]  write_reg;
      logic [3:0]  func_code;
      alu_op_e     alu_op;
      logic        alu_src_imm;
      logic [31:0] imm_ext;
   } ctrl_t;

endpackage

// File: rtl/instr_decode_ctrl_if.sv
// rtl/instr_decode_ctrl_if.sv - instruction handshake, datapath controls and status bundle
interface instr_decode_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             instr_valid;
   logic [31:0]      instr;
   logic             instr_ready;
   logic             Zero;
   logic [4:0]       Read1;
   logic [4:0]       Read2;
   logic [4:0]       WriteReg;
   logic [1:0]       RegWrite;
   logic [3:0]       FuncCode;
   logic [1:0]       ALUOp;
   logic             alu_src_imm;
   logic [31:0]      imm_ext;
   logic             branch_taken;
   logic             done;
   logic             illegal;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output instr_valid, instr, Zero,
      input  instr_ready, Read1, Read2, WriteReg, RegWrite, FuncCode, ALUOp,
             alu_src_imm, imm_ext, branch_taken, done, illegal, instr_count
   );

   modport slave (
      input  instr_valid, instr, Zero,
      output instr_ready, Read1, Read2, WriteReg, RegWrite, FuncCode, ALUOp,
             alu_src_imm, imm_ext, branch_taken, done, illegal, instr_count
   );
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational map from instruction word to control bundle and flags
module instr_decoder
   import isa_pkg::*;
(
   input  logic [31:0] ir,
   output ctrl_t       ctrl,
   output logic        legal,
   output logic        writes_reg,
   output logic        is_beq
);
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign opcode   = ir[31:26];
   assign funct    = ir[5:0];
   assign imm_sext = {{16{ir[15]}}, ir[15:0]};
   assign imm_zext = {16'h0000, ir[15:0]};

   always_comb begin
      ctrl       = '0;
      ctrl.read1 = ir[25:21];
      ctrl.read2 = ir[20:16];
      legal      = 1'b0;
      writes_reg = 1'b0;
      is_beq     = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT}) begin
               legal          = 1'b1;
               writes_reg     = 1'b1;
               ctrl.alu_op    = ALU_FUNC;
               ctrl.func_code = funct[3:0];
               ctrl.write_reg = ir[15:11];
            end
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            legal            = 1'b1;
            writes_reg       = 1'b1;
            ctrl.alu_op      = ALU_FUNC;
            ctrl.alu_src_imm = 1'b1;
            ctrl.write_reg   = ir[20:16];
            // Logical immediates are zero-extended, arithmetic ones sign-extended.
            case (opcode)
               OP_ADDI: begin ctrl.func_code = FC_ADD; ctrl.imm_ext = imm_sext; end
               OP_SLTI: begin ctrl.func_code = FC_SLT; ctrl.imm_ext = imm_sext; end
               OP_ANDI: begin ctrl.func_code = FC_AND; ctrl.imm_ext = imm_zext; end
               default: begin ctrl.func_code = FC_OR;  ctrl.imm_ext = imm_zext; end
            endcase
         end
         OP_BEQ: begin
            legal        = 1'b1;
            is_beq       = 1'b1;
            ctrl.alu_op  = ALU_SUB;
            ctrl.imm_ext = imm_sext;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/instr_decode_ctrl.sv
// rtl/instr_decode_ctrl.sv - four-state decode/control sequencer for the ALU + register file
module instr_decode_ctrl
   import isa_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_decode_ctrl_if.slave bus
);
   state_e           state_d, state_q;
   logic [31:0]      ir_d, ir_q;
   ctrl_t            ctrl_d, ctrl_q, dec_ctrl;
   logic             dec_legal, dec_writes, dec_beq;
   logic             legal_d, legal_q;
   logic             writes_d, writes_q;
   logic             beq_d, beq_q;
   logic [1:0]       reg_write_d, reg_write_q;
   logic             done_d, done_q;
   logic             illegal_d, illegal_q;
   logic             z_d, z_q;
   logic             ready_d, ready_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             accept;

   assign accept = (state_q == ST_IDLE) && bus.instr_valid;
   assign ir_d   = accept ? bus.instr : ir_q;

   // Decoding the incoming word lets the controls be registered at the accept edge.
   instr_decoder u_decoder (
      .ir         (ir_d),
      .ctrl       (dec_ctrl),
      .legal      (dec_legal),
      .writes_reg (dec_writes),
      .is_beq     (dec_beq)
   );

   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      legal_d     = legal_q;
      writes_d    = writes_q;
      beq_d       = beq_q;
      cnt_d       = cnt_q;
      reg_write_d = 2'b00;
      done_d      = 1'b0;
      illegal_d   = 1'b0;
      z_d         = 1'b0;
      ready_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_DECODE;
               ctrl_d   = dec_ctrl;
               legal_d  = dec_legal;
               writes_d = dec_writes;
               beq_d    = dec_beq;
            end else begin
               ready_d  = 1'b1;
            end
         end
         ST_DECODE: begin
            if (legal_q) begin
               state_d   = ST_EXECUTE;
            end else begin
               state_d   = ST_IDLE;
               ctrl_d    = '0;
               legal_d   = 1'b0;
               writes_d  = 1'b0;
               beq_d     = 1'b0;
               illegal_d = 1'b1;
               ready_d   = 1'b1;
            end
         end
         ST_EXECUTE: begin
            state_d     = ST_WRITEBACK;
            reg_write_d = (writes_q && (ctrl_q.write_reg != 5'd0)) ? 2'b01 : 2'b00;
            done_d      = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
            z_d         = beq_q && bus.Zero;
         end
         default: begin
            state_d  = ST_IDLE;
            ctrl_d   = '0;
            legal_d  = 1'b0;
            writes_d = 1'b0;
            beq_d    = 1'b0;
            ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ir_q        <= '0;
         ctrl_q      <= '0;
         legal_q     <= 1'b0;
         writes_q    <= 1'b0;
         beq_q       <= 1'b0;
         reg_write_q <= 2'b00;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         z_q         <= 1'b0;
         ready_q     <= 1'b1;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         ctrl_q      <= ctrl_d;
         legal_q     <= legal_d;
         writes_q    <= writes_d;
         beq_q       <= beq_d;
         reg_write_q <= reg_write_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
         z_q         <= z_d;
         ready_q     <= ready_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.instr_ready  = ready_q;
   assign bus.Read1        = ctrl_q.read1;
   assign bus.Read2        = ctrl_q.read2;
   assign bus.WriteReg     = ctrl_q.write_reg;
   assign bus.RegWrite     = reg_write_q;
   assign bus.FuncCode     = ctrl_q.func_code;
   assign bus.ALUOp        = ctrl_q.alu_op;
   assign bus.alu_src_imm  = ctrl_q.alu_src_imm;
   assign bus.imm_ext      = ctrl_q.imm_ext;
   assign bus.branch_taken = z_q;
   assign bus.done         = done_q;
   assign bus.illegal      = illegal_q;
   assign bus.instr_count  = cnt_q;
endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb/tb_instr_decode_ctrl.sv - directed vectors checked against an instruction-level model
module tb_instr_decode_ctrl;
   localparam int CNT_W = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   instr_decode_ctrl_if #(.CNT_W(CNT_W)) bus ();

   instr_decode_ctrl #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        legal;
      logic        wr;
      logic        beq;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  wreg;
      logic [3:0]  fc;
      logic [1:0]  aop;
      logic        src;
      logic [31:0] imm;
   } exp_t;

   function automatic exp_t model_decode(input logic [31:0] w);
      exp_t        e;
      int          op;
      int          fn;
      logic [31:0] se;
      logic [31:0] ze;
      op = int'(w[31:26]);
      fn = int'(w[5:0]);
      se = {{16{w[15]}}, w[15:0]};
      ze = {16'h0000, w[15:0]};
      e = '0;
      e.r1 = w[25:21];
      e.r2 = w[20:16];
      if (op == 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 39 || fn == 42)) begin
         e.legal = 1; e.wr = 1; e.aop = 2; e.fc = 4'(fn % 16); e.wreg = w[15:11];
      end else if (op == 8 || op == 10 || op == 12 || op == 13) begin
         e.legal = 1; e.wr = 1; e.aop = 2; e.src = 1; e.wreg = w[20:16];
         e.fc  = (op == 8) ? 4'd0 : (op == 10) ? 4'd10 : (op == 12) ? 4'd4 : 4'd5;
         e.imm = (op >= 12) ? ze : se;
      end else if (op == 4) begin
         e.legal = 1; e.beq = 1; e.aop = 1; e.imm = se;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: age counts cycles since acceptance (0 = idle).
   int          m_age = 0;
   int          m_cnt = 0;
   logic        m_ill = 1'b0;
   logic        m_z = 1'b0;
   logic [31:0] m_cur = '0;
   exp_t        m_e;

   always_comb m_e = model_decode(m_cur);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_age <= 0; m_cnt <= 0; m_ill <= 1'b0; m_z <= 1'b0; m_cur <= '0;
      end else begin
         m_ill <= 1'b0;
         case (m_age)
            0: if (bus.instr_valid) begin m_cur <= bus.instr; m_age <= 1; end
            1: if (m_e.legal) m_age <= 2; else begin m_age <= 0; m_ill <= 1'b1; end
            2: begin m_age <= 3; m_cnt <= (m_cnt + 1) % CNT_MOD; m_z <= m_e.beq && bus.Zero; end
            default: begin m_age <= 0; m_z <= 1'b0; end
         endcase
      end
   end

   always @(negedge clk) begin
      exp_t x;
      x = (m_age == 0) ? exp_t'(0) : m_e;
      chk("instr_ready", bus.instr_ready, m_age == 0);
      chk("done", bus.done, m_age == 3);
      chk("illegal", bus.illegal, m_ill);
      chk("RegWrite", bus.RegWrite, (m_age == 3 && m_e.wr && m_e.wreg != 0) ? 2'b01 : 2'b00);
      chk("branch_taken", bus.branch_taken, m_age == 3 && m_z);
      chk("instr_count", bus.instr_count, m_cnt);
      if (m_age == 0 || m_e.legal) begin
         chk("Read1", bus.Read1, x.r1);
         chk("Read2", bus.Read2, x.r2);
         chk("WriteReg", bus.WriteReg, x.wreg);
         chk("FuncCode", bus.FuncCode, x.fc);
         chk("ALUOp", bus.ALUOp, x.aop);
         chk("alu_src_imm", bus.alu_src_imm, x.src);
         chk("imm_ext", bus.imm_ext, x.imm);
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [31:0] w, input logic z);
      wait_ready();
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      bus.Zero        = z;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
   endtask

   logic [31:0] others [7] = '{32'h00221822, 32'h00221824, 32'h00221825, 32'h00221827,
                               32'h0022182A, 32'h2885FFFF, 32'h3485FFFF};

   initial begin
      int hs;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.Zero        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.instr_ready, 1);
      chk("rst_count", bus.instr_count, 0);
      chk("rst_regwrite", bus.RegWrite, 0);
      rst_n = 1'b1;

      send(32'h00221820, 1'b0);
      @(negedge clk);
      chk("add_read1", bus.Read1, 1);
      chk("add_read2", bus.Read2, 2);
      chk("add_wreg", bus.WriteReg, 3);
      chk("add_aluop", bus.ALUOp, 2'b10);
      chk("add_func", bus.FuncCode, 4'b0000);
      chk("add_rw_early", bus.RegWrite, 0);
      @(negedge clk);
      chk("add_done_early", bus.done, 0);
      @(negedge clk);
      chk("add_rw", bus.RegWrite, 2'b01);
      chk("add_done", bus.done, 1);
      chk("add_count", bus.instr_count, 1);

      send(32'h30858000, 1'b0);
      @(negedge clk);
      chk("andi_src", bus.alu_src_imm, 1);
      chk("andi_imm", bus.imm_ext, 32'h00008000);
      chk("andi_wreg", bus.WriteReg, 5);

      send(32'h20858000, 1'b0);
      @(negedge clk);
      chk("addi_imm", bus.imm_ext, 32'hFFFF8000);

      send(32'h10220004, 1'b1);
      repeat (3) @(negedge clk);
      chk("beq1_taken", bus.branch_taken, 1);
      chk("beq1_rw", bus.RegWrite, 0);
      chk("beq1_done", bus.done, 1);

      send(32'h10220004, 1'b0);
      repeat (3) @(negedge clk);
      chk("beq0_taken", bus.branch_taken, 0);
      chk("beq0_done", bus.done, 1);

      send(32'hFC000000, 1'b0);
      repeat (2) @(negedge clk);
      chk("ill_op_pulse", bus.illegal, 1);
      chk("ill_op_ready", bus.instr_ready, 1);
      chk("ill_op_done", bus.done, 0);
      chk("ill_op_count", bus.instr_count, 5);

      send(32'h00221800, 1'b0);
      repeat (2) @(negedge clk);
      chk("ill_fn_pulse", bus.illegal, 1);

      send(32'h00220020, 1'b0);
      repeat (3) @(negedge clk);
      chk("r0_rw", bus.RegWrite, 0);
      chk("r0_done", bus.done, 1);
      chk("r0_count", bus.instr_count, 6);

      foreach (others[i]) begin
         send(others[i], 1'b0);
         repeat (3) @(negedge clk);
      end

      wait_ready();
      bus.instr_valid = 1'b1;
      bus.instr       = 32'h00221820;
      hs = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.instr_ready && bus.instr_valid) hs++;
         @(negedge clk);
      end
      bus.instr_valid = 1'b0;
      chk("b2b_accepts", hs, 3);
      chk("wrap_count", bus.instr_count, 0);

      send(32'h00221820, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_rw", bus.RegWrite, 0);
      chk("abort_read1", bus.Read1, 0);
      chk("abort_ready", bus.instr_ready, 1);
      chk("abort_count", bus.instr_count, 0);
      chk("abort_done", bus.done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      send(32'h00221820, 1'b0);
      repeat (3) @(negedge clk);
      chk("post_rst_done", bus.done, 1);
      chk("post_rst_count", bus.instr_count, 1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
